// File: rtl/airlink_dsp_pkg.sv
// Shared constants and types for the airlink DSP user logic: sample width,
// saturation limits, CtrlPort shift register map and packet-tracking state.
package airlink_dsp_pkg;

    localparam int DEF_SAMP_W = 16;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    localparam logic [19:0] SHIFT_REG_ADDR    = 20'h00010;
    localparam logic [4:0]  SHIFT_REG_DEFAULT = 5'd0;

    typedef enum logic {
        PKT_SOP  = 1'b0,
        PKT_BODY = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/iq_sat_shift.sv
// Single-component clamp of a sign-extended, already-shifted value back into
// SAMP_W signed bits, with a flag marking that saturation occurred.
module iq_sat_shift
    import airlink_dsp_pkg::*;
#(
    parameter int SAMP_W = DEF_SAMP_W,
    parameter int EXT_W  = SAMP_W + 32
) (
    input  logic [EXT_W-1:0]  wide,
    output logic [SAMP_W-1:0] samp,
    output logic              sat
);

    logic in_range;

    // Representable iff every bit from the target sign bit upward agrees.
    assign in_range = (&wide[EXT_W-1:SAMP_W-1]) | ~(|wide[EXT_W-1:SAMP_W-1]);

    always_comb begin
        sat  = ~in_range;
        samp = wide[SAMP_W-1:0];
        if (!in_range) begin
            if (wide[EXT_W-1]) begin
                samp = {1'b1, {(SAMP_W-1){1'b0}}};
            end else begin
                samp = {1'b0, {(SAMP_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/iq_shift_left_sat.sv
// Streaming sc16 gain stage: per-packet left shift of I and Q with saturation,
// two-stage AXI-Stream pipeline and a sticky saturation event counter.
module iq_shift_left_sat
    import airlink_dsp_pkg::*;
#(
    parameter int SAMP_W  = DEF_SAMP_W,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SHIFT_W-1:0]    shift_cfg,
    input  logic                  clear_sat_cnt,
    input  logic [2*SAMP_W-1:0]   s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [2*SAMP_W-1:0]   m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [CNT_W-1:0]      sat_count
);

    localparam int EXT_W = SAMP_W + 32;

    logic                     v1_reg;
    logic                     v2_reg;
    logic                     last1_reg;
    logic                     en1;
    logic                     en2;
    logic                     accept;
    logic                     load;
    pkt_state_t               pkt_state_reg;
    logic [SHIFT_W-1:0]       shift_lat_reg;
    logic [SHIFT_W-1:0]       shift_eff;
    logic [1:0][SAMP_W-1:0]   clamped;
    logic [1:0]               sat;
    logic [1:0]               sat_inc;
    logic [CNT_W:0]           cnt_sum;

    assign en2           = !v2_reg | m_axis_tready;
    assign en1           = !v1_reg | en2;
    assign s_axis_tready = en1;
    assign accept        = s_axis_tvalid & en1;
    assign load          = v1_reg & en2;
    assign m_axis_tvalid = v2_reg;

    // First beat of a packet takes the live register value; the rest reuse the latch.
    assign shift_eff = (pkt_state_reg == PKT_SOP) ? shift_cfg : shift_lat_reg;

    // Lane 0 is Q (low half), lane 1 is I (high half).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [SAMP_W-1:0] comp_in;
            logic [EXT_W-1:0]  comp_ext;
            logic [EXT_W-1:0]  stage1_reg;

            assign comp_in  = s_axis_tdata[gi*SAMP_W +: SAMP_W];
            assign comp_ext = {{32{comp_in[SAMP_W-1]}}, comp_in};

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage1_reg <= '0;
                end else if (accept) begin
                    stage1_reg <= comp_ext << shift_eff;
                end
            end

            iq_sat_shift #(
                .SAMP_W (SAMP_W),
                .EXT_W  (EXT_W)
            ) u_sat (
                .wide (stage1_reg),
                .samp (clamped[gi]),
                .sat  (sat[gi])
            );
        end
    endgenerate

    assign sat_inc = {1'b0, sat[0]} + {1'b0, sat[1]};
    assign cnt_sum = {1'b0, sat_count} + {{(CNT_W-1){1'b0}}, sat_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            last1_reg     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            pkt_state_reg <= PKT_SOP;
            shift_lat_reg <= '0;
            sat_count     <= '0;
        end else begin
            if (en1) begin
                v1_reg <= s_axis_tvalid;
            end
            if (accept) begin
                last1_reg <= s_axis_tlast;
                if (pkt_state_reg == PKT_SOP) begin
                    shift_lat_reg <= shift_cfg;
                end
                pkt_state_reg <= s_axis_tlast ? PKT_SOP : PKT_BODY;
            end

            if (en2) begin
                v2_reg <= v1_reg;
                if (v1_reg) begin
                    m_axis_tdata <= clamped;
                    m_axis_tlast <= last1_reg;
                end
            end

            // A clear coinciding with a load keeps only that beat's events.
            if (clear_sat_cnt) begin
                sat_count <= load ? {{(CNT_W-2){1'b0}}, sat_inc} : '0;
            end else if (load) begin
                sat_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            end
        end
    end

endmodule
